// File: rtl/fmc_master.sv
// fmc_master: single-beat FMC bus initiator turning fabric commands into FMC read/write cycles
module fmc_master #(
  parameter int FMC_AW = 20,
  parameter int DW = 32,
  parameter int LAT = 2,
  parameter int TURN = 1
) (
  input  logic              fmc_clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [FMC_AW-1:0] cmd_addr,
  input  logic [DW-1:0]     cmd_wdata,
  output logic              rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              busy,
  output logic [FMC_AW-1:0] fmc_a,
  inout  wire  [DW-1:0]     fmc_d,
  output logic              fmc_ne,
  output logic              fmc_noe,
  output logic              fmc_nwe
);
  typedef enum logic [2:0] {IDLE, ADDR, WAIT, DATA, TURN_ST} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, ne_q, ne_d, noe_q, noe_d, nwe_q, nwe_d, oe_q, oe_d, rv_q, rv_d, act;
  logic [FMC_AW-1:0] a_q, a_d;
  logic [DW-1:0] wdata_q, wdata_d, rd_q, rd_d;
  // Next-state and next bus levels; bus strobes are derived from the next state so they come out of flops
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    we_d = we_q;
    a_d = a_q;
    wdata_d = wdata_q;
    rv_d = 1'b0;
    rd_d = rd_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = ADDR;
        we_d = cmd_we;
        a_d = cmd_addr;
        wdata_d = cmd_wdata;
      end
      ADDR: begin
        cnt_d = 4'(LAT);
        state_d = (LAT == 0) ? DATA : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? DATA : WAIT;
      end
      DATA: begin
        cnt_d = 4'(TURN);
        state_d = (TURN == 0) ? IDLE : TURN_ST;
        rv_d = !we_q;
        rd_d = we_q ? rd_q : fmc_d;
      end
      TURN_ST: begin
        cnt_d = cnt_q - 4'd1;
        state_d = (cnt_q == 4'd1) ? IDLE : TURN_ST;
      end
      default: state_d = IDLE;
    endcase
    act = (state_d == ADDR) || (state_d == WAIT) || (state_d == DATA);
    ne_d = !act;
    noe_d = !(act && !we_d);
    nwe_d = !(act && we_d);
    oe_d = act && we_d;
  end
  // State, latched command and registered bus outputs; reset forces the bus idle immediately
  always_ff @(posedge fmc_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      a_q <= '0;
      wdata_q <= '0;
      ne_q <= 1'b1;
      noe_q <= 1'b1;
      nwe_q <= 1'b1;
      oe_q <= 1'b0;
      rv_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      a_q <= a_d;
      wdata_q <= wdata_d;
      ne_q <= ne_d;
      noe_q <= noe_d;
      nwe_q <= nwe_d;
      oe_q <= oe_d;
      rv_q <= rv_d;
      rd_q <= rd_d;
    end
  end
  assign cmd_ready = (state_q == IDLE);
  assign busy = (state_q != IDLE);
  assign fmc_a = a_q;
  assign fmc_ne = ne_q;
  assign fmc_noe = noe_q;
  assign fmc_nwe = nwe_q;
  assign fmc_d = oe_q ? wdata_q : 'z;
  assign rsp_valid = rv_q;
  assign rsp_rdata = rd_q;
endmodule

// File: tb/tb_fmc_master.sv
// tb_fmc_master: scoreboard bench for fmc_master over three LAT/TURN configurations
module tb_fmc_master;
  typedef struct {
    logic we;
    logic [19:0] a;
    logic [31:0] d;
    int k;
  } txn_t;
  localparam logic [31:0] IDLE_PAT = 32'h5A5A_5A5A;
  int total = 0, passed = 0, cyc = 0;
  logic fmc_clk = 0;
  always #5 fmc_clk = ~fmc_clk;
  always @(posedge fmc_clk) cyc <= cyc + 1;
  function automatic logic [31:0] dflt(input logic [19:0] a);
    return {a[11:0], a} ^ 32'h3C3C_1234;
  endfunction
  task automatic chk(input int g, input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL cfg%0d %s: got %0h, required %0h", g, n, act, exp);
  endtask
  task automatic fail(input int g, input string n);
    total++;
    $display("FAIL cfg%0d %s: event not allowed by the reference model", g, n);
  endtask
  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int L = (g == 0) ? 2 : (g == 1) ? 0 : 15;
    localparam int T = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    logic rst = 0, cmd_valid = 0, cmd_we = 0, cmd_ready, rsp_valid, busy, fmc_ne, fmc_noe, fmc_nwe;
    logic [19:0] cmd_addr = 0, fmc_a;
    logic [31:0] cmd_wdata = 0, rsp_rdata, rd_val = 0, last_rd = 0;
    wire [31:0] fmc_d;
    logic drv = 0, mon_en = 0;
    bit fin = 0;
    int srun = 0, mrun = 0;
    txn_t bus_q[$], rsp_q[$], cur, r;
    logic [31:0] slave_mem [logic [19:0]];
    logic [31:0] ref_mem [logic [19:0]];
    assign fmc_d = fmc_ne ? IDLE_PAT : drv ? rd_val : 'z;
    fmc_master #(.FMC_AW(20), .DW(32), .LAT(L), .TURN(T)) dut (
      .fmc_clk(fmc_clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .busy(busy), .fmc_a(fmc_a), .fmc_d(fmc_d), .fmc_ne(fmc_ne),
      .fmc_noe(fmc_noe), .fmc_nwe(fmc_nwe)
    );
    // Slave memory model: acts in the (L+2)-th cycle of a chip-select window
    always @(negedge fmc_clk) begin
      srun = fmc_ne ? 0 : srun + 1;
      drv = 0;
      if (srun == L + 2) begin
        if (!fmc_nwe) slave_mem[fmc_a] = fmc_d;
        else if (!fmc_noe) begin
          rd_val = slave_mem.exists(fmc_a) ? slave_mem[fmc_a] : dflt(fmc_a);
          drv = 1;
        end
      end
    end
    // Monitor: pops expected bus transactions and responses as the DUT presents them
    always @(negedge fmc_clk) if (mon_en) begin
      if (!fmc_ne) begin
        if (mrun == 0) begin
          if (bus_q.size() == 0) begin
            fail(g, "spurious_txn");
            cur = '{1'b0, 20'h0, 32'h0, 0};
          end else begin
            cur = bus_q.pop_front();
            chk(g, "start_cyc", 64'(cyc), 64'(cur.k));
            chk(g, "addr", 64'(fmc_a), 64'(cur.a));
          end
        end
        chk(g, "strobes", 64'({fmc_noe, fmc_nwe}), cur.we ? 64'd2 : 64'd1);
        if (cur.we) chk(g, "wdata", 64'(fmc_d), 64'(cur.d));
        mrun++;
      end else begin
        if (mrun != 0) chk(g, "ne_low_len", 64'(mrun), 64'(L + 2));
        mrun = 0;
        chk(g, "idle_bus", 64'({fmc_noe, fmc_nwe, fmc_d}), 64'({2'b11, IDLE_PAT}));
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) fail(g, "spurious_rsp");
        else begin
          r = rsp_q.pop_front();
          chk(g, "rsp_cyc", 64'(cyc), 64'(r.k + L + 2));
          chk(g, "rdata", 64'(rsp_rdata), 64'(r.d));
          last_rd = r.d;
        end
      end else chk(g, "rdata_hold", 64'(rsp_rdata), 64'(last_rd));
      chk(g, "busy", 64'(busy), 64'(!cmd_ready));
    end
    task automatic send(input logic we, input logic [19:0] a, input logic [31:0] d, input bit hold);
      int n, k;
      cmd_we = we;
      cmd_addr = a;
      cmd_wdata = d;
      cmd_valid = 1;
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge fmc_clk); n++; end
      if (!cmd_ready) begin
        fail(g, "accept_timeout");
        cmd_valid = 0;
        return;
      end
      k = cyc + 1;
      bus_q.push_back('{we, a, d, k});
      if (we) ref_mem[a] = d;
      else rsp_q.push_back('{we, a, ref_mem.exists(a) ? ref_mem[a] : dflt(a), k});
      @(negedge fmc_clk);
      if (!hold) begin
        cmd_valid = 0;
        cmd_we = 1'($urandom);
        cmd_addr = 20'($urandom);
        cmd_wdata = $urandom;
      end
      n = 0;
      while (!cmd_ready && n < 100) begin @(negedge fmc_clk); n++; end
      chk(g, "ready_return", 64'(cyc), 64'(k + L + 2 + T));
    endtask
    // Stimulus: reset checks, directed transactions, then randomized traffic
    initial begin
      bit h;
      logic [19:0] a;
      if (g == 0) begin
        slave_mem[20'hFFFFF] = 32'hCAFEF00D;
        ref_mem[20'hFFFFF] = 32'hCAFEF00D;
      end
      #1 rst = 1;
      #1;
      chk(g, "rst_strobes", 64'({fmc_ne, fmc_noe, fmc_nwe}), 64'd7);
      chk(g, "rst_addr", 64'(fmc_a), 64'd0);
      chk(g, "rst_outs", 64'({cmd_ready, rsp_valid, busy}), 64'd4);
      chk(g, "rst_rdata", 64'(rsp_rdata), 64'd0);
      chk(g, "rst_fmc_d", 64'(fmc_d), 64'(IDLE_PAT));
      repeat (2) @(negedge fmc_clk);
      rst = 0;
      @(negedge fmc_clk);
      if (g == 0) begin
        cmd_we = 1;
        cmd_addr = 20'h00123;
        cmd_wdata = 32'hDEADBEEF;
        cmd_valid = 1;
        @(negedge fmc_clk);
        cmd_valid = 0;
        @(negedge fmc_clk);
        chk(g, "pre_rst_active", 64'({fmc_ne, fmc_nwe, cmd_ready}), 64'd0);
        rst = 1;
        #1;
        chk(g, "mid_rst_strobes", 64'({fmc_ne, fmc_noe, fmc_nwe}), 64'd7);
        chk(g, "mid_rst_fmc_d", 64'(fmc_d), 64'(IDLE_PAT));
        chk(g, "mid_rst_ready", 64'({cmd_ready, busy, rsp_valid}), 64'd4);
        @(negedge fmc_clk);
        rst = 0;
        repeat (6) begin
          @(negedge fmc_clk);
          chk(g, "post_rst_idle", 64'({rsp_valid, fmc_ne, cmd_ready}), 64'd3);
        end
      end
      mon_en = 1;
      if (g == 0) begin
        send(1, 20'h00123, 32'hDEADBEEF, 0);
        send(0, 20'hFFFFF, 32'h0, 0);
        send(1, 20'h00001, $urandom, 1);
        send(0, 20'h00002, 32'h0, 0);
      end
      repeat (40) begin
        h = ($urandom_range(0, 2) == 0);
        a = $urandom_range(0, 1) ? 20'($urandom_range(0, 15)) : 20'($urandom);
        send(1'($urandom), a, $urandom, h);
        if (!h) repeat ($urandom_range(0, 2)) @(negedge fmc_clk);
      end
      send(0, 20'h00003, 32'h0, 0);
      repeat (L + T + 6) @(negedge fmc_clk);
      chk(g, "drain", 64'(bus_q.size() + rsp_q.size()), 64'd0);
      fin = 1;
    end
  end
  initial begin
    int n;
    n = 0;
    while (!(cfg[0].fin && cfg[1].fin && cfg[2].fin) && n < 50000) begin
      @(negedge fmc_clk);
      n++;
    end
    if (!(cfg[0].fin && cfg[1].fin && cfg[2].fin)) fail(-1, "global_timeout");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
